// File: rtl/tbu_213.sv
// Traceback / survivor-memory unit for the 8-state (2,1,3) Viterbi decoder.
// Block mode: FILL stores one decision vector per trellis step, TRACE walks
// the survivor path backwards from the supplied end state (one step per cycle),
// and EMIT streams the decoded bits in transmission order over valid/ready.
module tbu_213 #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [7:0] dec_bx,
  input  logic       dec_last,
  input  logic [2:0] start_state,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     len_q, len_d;
  logic [2:0]      cur_state_q, cur_state_d;
  logic            bit_valid_q, bit_valid_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_last_q, bit_last_d;
  logic            busy_q;

  logic [7:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] obuf_q;

  logic            mem_we_s;
  logic            obuf_we_s;
  logic            dec_bit_s;
  logic [AW-1:0]   rd_next_s;

  // Survivor memory is read combinationally; the decision bit for the current
  // path state selects the predecessor.
  assign dec_bit_s = mem_q[idx_q][cur_state_q];
  assign rd_next_s = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};

  // Next-state, pointer and output-register logic for the FILL/TRACE/EMIT FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cur_state_d = cur_state_q;
    bit_valid_d = bit_valid_q;
    bit_out_d   = bit_out_q;
    bit_last_d  = bit_last_q;
    mem_we_s    = 1'b0;
    obuf_we_s   = 1'b0;
    case (state_q)
      FILL: begin
        if (dec_valid) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          if (dec_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            len_d       = {1'b0, wr_ptr_q} + {{AW{1'b0}}, 1'b1};
            cur_state_d = start_state;
            idx_d       = wr_ptr_q;
            state_d     = TRACE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      TRACE: begin
        obuf_we_s   = 1'b1;
        cur_state_d = {cur_state_q[1:0], dec_bit_s};
        idx_d       = idx_q - {{(AW-1){1'b0}}, 1'b1};
        if (idx_q == {AW{1'b0}}) begin
          // obuf[0] is written this same edge, so forward it into bit_out.
          rd_ptr_d    = {AW{1'b0}};
          state_d     = EMIT;
          bit_valid_d = 1'b1;
          bit_out_d   = cur_state_q[2];
          bit_last_d  = (len_q == {{AW{1'b0}}, 1'b1});
        end else begin
          state_d = TRACE;
        end
      end
      EMIT: begin
        if (bit_ready) begin
          rd_ptr_d = rd_next_s;
          if (bit_last_q) begin
            wr_ptr_d    = {AW{1'b0}};
            state_d     = FILL;
            bit_valid_d = 1'b0;
            bit_out_d   = 1'b0;
            bit_last_d  = 1'b0;
          end else begin
            bit_out_d  = obuf_q[rd_next_s];
            bit_last_d = ({1'b0, rd_next_s} == (len_q - {{AW{1'b0}}, 1'b1}));
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d     = FILL;
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        bit_last_d  = 1'b0;
      end
    endcase
  end

  // State, pointers and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      idx_q       <= {AW{1'b0}};
      len_q       <= {(AW+1){1'b0}};
      cur_state_q <= 3'd0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cur_state_q <= cur_state_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_last_q  <= bit_last_d;
      busy_q      <= (state_d != FILL);
    end
  end

  // Survivor memory and decoded-bit buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= dec_bx;
    end
    if (obuf_we_s) begin
      obuf_q[idx_q] <= cur_state_q[2];
    end
  end

  assign dec_ready = (state_q == FILL);
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign bit_last  = bit_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tbu_213.sv
// Directed, table-driven bench for tbu_213 with hand-computed decoded bits.
module tb_tbu_213;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid;
  logic       dec_ready;
  logic [7:0] dec_bx;
  logic       dec_last;
  logic [2:0] start_state;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       bit_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tbu_213 dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_bx(dec_bx),
    .dec_last(dec_last), .start_state(start_state),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_last(bit_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Short blocks: bx holds step i in bits [8*i +: 8]; exp bit i = decoded bit of step i.
  typedef struct {
    int          n;
    logic [31:0] bx;
    logic [2:0]  st;
    logic [3:0]  exp;
    int          stall;
    bit          noise;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Feed n decisions, check TRACE latency, then consume n bits with optional stalls.
  task automatic run_block(input int n, input logic [7:0] bx [64], input logic [2:0] st,
                           input logic [63:0] exp, input bit use_last, input int stall,
                           input bit noise, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dec_valid   = 1'b1;
      dec_bx      = bx[i];
      dec_last    = use_last && (i == n - 1);
      start_state = (i == n - 1) ? st : 3'($urandom_range(7, 0));
      chk({tag, " dec_ready_fill"}, {63'd0, dec_ready}, 64'd1);
      @(posedge clk);
    end
    // n TRACE cycles: no output yet, busy high, decisions refused.
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (noise) begin
        dec_valid = 1'b1;
        dec_bx    = 8'($urandom);
        dec_last  = 1'($urandom);
      end else begin
        dec_valid = 1'b0;
        dec_last  = 1'b0;
      end
      chk({tag, " trace_valid_low"}, {63'd0, bit_valid}, 64'd0);
      chk({tag, " trace_busy"}, {61'd0, busy, dec_ready, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
    end
    for (int j = 0; j < n; j++) begin
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        bit_ready = (s == stall);
        chk({tag, " emit_valid"}, {63'd0, bit_valid}, 64'd1);
        chk({tag, " emit_bit"}, {63'd0, bit_out}, {63'd0, exp[j]});
        chk({tag, " emit_last"}, {63'd0, bit_last}, {63'd0, (j == n - 1)});
        chk({tag, " emit_ready_busy"}, {62'd0, dec_ready, busy}, {62'd0, 1'b0, 1'b1});
      end
    end
    @(negedge clk);
    bit_ready = 1'b0;
    dec_valid = 1'b0;
    dec_last  = 1'b0;
    chk({tag, " done_valid_low"}, {63'd0, bit_valid}, 64'd0);
    chk({tag, " done_fill"}, {62'd0, dec_ready, busy}, {62'd0, 1'b1, 1'b0});
  endtask

  vec_t        vecs [7];
  logic [7:0]  bxa [64];
  logic [63:0] expa;

  initial begin
    // bx byte per step (step 0 in low byte), start state, expected bits (bit i = step i)
    vecs[0] = '{4, 32'h00000000, 3'd0, 4'b0000, 0, 1'b0};
    vecs[1] = '{4, 32'h40000000, 3'd6, 4'b1101, 0, 1'b0}; // message 1,0,1,1
    vecs[2] = '{4, 32'h40000000, 3'd6, 4'b1101, 3, 1'b0}; // same, backpressure
    vecs[3] = '{4, 32'h00000000, 3'd7, 4'b1110, 0, 1'b1}; // 7->6->4->0, noise on dec_valid
    vecs[4] = '{4, 32'hFFFFFFFF, 3'd0, 4'b0001, 1, 1'b0}; // 0->1->3->7
    vecs[5] = '{1, 32'h00000000, 3'd4, 4'b0001, 0, 1'b0}; // len = 1
    vecs[6] = '{1, 32'h000000FF, 3'd3, 4'b0000, 2, 1'b1};

    rst_n = 1'b0; dec_valid = 1'b0; dec_bx = 8'd0; dec_last = 1'b0;
    start_state = 3'd0; bit_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {60'd0, bit_valid, bit_last, bit_out, busy}, 64'd0);
    chk("reset_ready", {63'd0, dec_ready}, 64'd1);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 64; i++) bxa[i] = (i < 4) ? vecs[v].bx[8*i +: 8] : 8'd0;
      expa = {60'd0, vecs[v].exp};
      run_block(vecs[v].n, bxa, vecs[v].st, expa, 1'b1, vecs[v].stall, vecs[v].noise,
                $sformatf("v%0d", v));
    end

    // Full depth, no dec_last: from end state 7 the path is 7,6,4,0,0,...
    for (int i = 0; i < 64; i++) bxa[i] = 8'd0;
    expa = 64'hE000_0000_0000_0000;
    run_block(64, bxa, 3'd7, expa, 1'b0, 0, 1'b1, "depth64");

    // Exact latency: last accept edge, then bit_valid only after 4 more edges.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1'b1; dec_bx = (i == 3) ? 8'h40 : 8'h00;
      dec_last = (i == 3); start_state = 3'd6;
      @(negedge clk);
    end
    dec_valid = 1'b0; dec_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_before", {63'd0, bit_valid}, 64'd0);
    @(negedge clk);
    chk("lat_at", {62'd0, bit_valid, bit_out}, {62'd0, 1'b1, 1'b1});
    bit_ready = 1'b1;
    repeat (4) @(negedge clk);
    bit_ready = 1'b0;
    chk("lat_done", {62'd0, bit_valid, dec_ready}, {62'd0, 1'b0, 1'b1});

    // Reset mid-TRACE of a 10-step block aborts it.
    for (int i = 0; i < 10; i++) begin
      dec_valid = 1'b1; dec_bx = 8'($urandom);
      dec_last = (i == 9); start_state = 3'd5;
      @(negedge clk);
    end
    dec_valid = 1'b0; dec_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_trace", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_now", {61'd0, bit_valid, dec_ready, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    bit_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_bits", {62'd0, bit_valid, busy}, 64'd0);
    end
    bit_ready = 1'b0;
    for (int i = 0; i < 64; i++) bxa[i] = 8'd0;
    expa = 64'd0;
    run_block(4, bxa, 3'd0, expa, 1'b1, 0, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
